// File: rtl/rv32i_id_stage.sv
// rtl/rv32i_id_stage.sv - RV32I instruction decode stage behind a 2-entry skid buffer.
// Decoded bundles are registered; the skid entry absorbs the cycle of latency on if_ready.
module rv32i_id_stage #(
  parameter int XLEN       = 32,
  parameter bit NOP_BUBBLE = 1'b1
) (
  input  logic            pad_clk,
  input  logic            pad_rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [3:0]      id_class,
  output logic [2:0]      id_funct3,
  output logic            id_alt,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [31:0]     id_imm,
  output logic            id_rd_we,
  output logic            id_rs1_used,
  output logic            id_rs2_used,
  output logic            id_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPRI   = 7'b0010011;
  localparam logic [6:0] OP_OPRR   = 7'b0110011;

  localparam logic [3:0] CLS_NOP    = 4'd0;
  localparam logic [3:0] CLS_LUI    = 4'd1;
  localparam logic [3:0] CLS_AUIPC  = 4'd2;
  localparam logic [3:0] CLS_JAL    = 4'd3;
  localparam logic [3:0] CLS_JALR   = 4'd4;
  localparam logic [3:0] CLS_BRANCH = 4'd5;
  localparam logic [3:0] CLS_LOAD   = 4'd6;
  localparam logic [3:0] CLS_STORE  = 4'd7;
  localparam logic [3:0] CLS_OPRI   = 4'd8;
  localparam logic [3:0] CLS_OPRR   = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [2:0]      funct3;
    logic            alt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic        legal;
  logic        wr;
  logic        r1;
  logic        r2;
  bundle_t     dec;

  always_comb begin
    opcode = if_inst[6:0];
    f3     = if_inst[14:12];
    f7     = if_inst[31:25];
    imm_i  = {{20{if_inst[31]}}, if_inst[31:20]};
    legal  = 1'b1;
    wr     = 1'b0;
    r1     = 1'b0;
    r2     = 1'b0;
    dec        = '0;
    dec.pc     = if_pc;
    dec.funct3 = f3;
    dec.rd     = if_inst[11:7];
    dec.rs1    = if_inst[19:15];
    dec.rs2    = if_inst[24:20];
    case (opcode)
      OP_LUI: begin
        dec.cls = CLS_LUI;
        dec.imm = {if_inst[31:12], 12'b0};
        wr      = 1'b1;
      end
      OP_AUIPC: begin
        dec.cls = CLS_AUIPC;
        dec.imm = {if_inst[31:12], 12'b0};
        wr      = 1'b1;
      end
      OP_JAL: begin
        dec.cls = CLS_JAL;
        dec.imm = {{12{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
        wr      = 1'b1;
      end
      OP_JALR: begin
        dec.cls = CLS_JALR;
        dec.imm = imm_i;
        wr      = 1'b1;
        r1      = 1'b1;
        legal   = (f3 == 3'b000);
      end
      OP_BRANCH: begin
        dec.cls = CLS_BRANCH;
        dec.imm = {{20{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
        r1      = 1'b1;
        r2      = 1'b1;
        legal   = (f3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        dec.cls = CLS_LOAD;
        dec.imm = imm_i;
        wr      = 1'b1;
        r1      = 1'b1;
        legal   = !((f3 == 3'b011) || (f3[2:1] == 2'b11));
      end
      OP_STORE: begin
        dec.cls = CLS_STORE;
        dec.imm = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
        r1      = 1'b1;
        r2      = 1'b1;
        legal   = !f3[2] && (f3 != 3'b011);
      end
      OP_OPRI: begin
        dec.cls = CLS_OPRI;
        wr      = 1'b1;
        r1      = 1'b1;
        dec.alt = (f3 == 3'b101) && if_inst[30];
        // Shift-immediates carry a 5-bit shamt, not a sign-extended constant
        if (f3 == 3'b001) begin
          dec.imm = {27'b0, if_inst[24:20]};
          legal   = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec.imm = {27'b0, if_inst[24:20]};
          legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end else begin
          dec.imm = imm_i;
        end
      end
      OP_OPRR: begin
        dec.cls = CLS_OPRR;
        wr      = 1'b1;
        r1      = 1'b1;
        r2      = 1'b1;
        dec.alt = if_inst[30];
        legal   = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      default: begin
        dec.cls = CLS_NOP;
        legal   = NOP_BUBBLE && (if_inst == 32'b0);
      end
    endcase
    dec.illegal  = !legal;
    dec.rd_we    = legal && wr && (dec.rd != 5'd0);
    dec.rs1_used = legal && r1;
    dec.rs2_used = legal && r2;
  end

  state_t  state_q, state_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    if_ready_q, if_ready_d;
  logic    id_valid_q, id_valid_d;
  logic    accept;
  logic    pop;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    accept  = if_valid && if_ready_q;
    pop     = id_valid_q && id_ready;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_d   = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !pop) begin
            skid_d  = dec;
            state_d = S_TWO;
          end else if (accept && pop) begin
            out_d = dec;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            out_d   = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    if_ready_d = (state_d != S_TWO);
    id_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge pad_clk) begin
    if (pad_rst) begin
      state_q    <= S_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      if_ready_q <= if_ready_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign if_ready    = if_ready_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = out_q.pc;
  assign id_class    = out_q.cls;
  assign id_funct3   = out_q.funct3;
  assign id_alt      = out_q.alt;
  assign id_rd       = out_q.rd;
  assign id_rs1      = out_q.rs1;
  assign id_rs2      = out_q.rs2;
  assign id_imm      = out_q.imm;
  assign id_rd_we    = out_q.rd_we;
  assign id_rs1_used = out_q.rs1_used;
  assign id_rs2_used = out_q.rs2_used;
  assign id_illegal  = out_q.illegal;

endmodule

// File: tb/tb_rv32i_id_stage.sv
// tb/tb_rv32i_id_stage.sv - randomized bench for rv32i_id_stage against a queue-based reference model.
module tb_rv32i_id_stage;

  logic        pad_clk = 1'b0;
  logic        pad_rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [3:0]  id_class;
  logic [2:0]  id_funct3;
  logic        id_alt;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] id_imm;
  logic        id_rd_we;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        id_illegal;

  rv32i_id_stage #(.XLEN(32), .NOP_BUBBLE(1'b1)) dut (
    .pad_clk(pad_clk), .pad_rst(pad_rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_class(id_class),
    .id_funct3(id_funct3), .id_alt(id_alt), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_imm(id_imm), .id_rd_we(id_rd_we), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_illegal(id_illegal)
  );

  always #5 pad_clk = ~pad_clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_we;
    logic        rs1u;
    logic        rs2u;
    logic        ill;
  } exp_t;

  localparam logic [6:0] OPS [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  exp_t exp_q[$];
  int   checks_n = 0;
  int   errors_n = 0;
  bit   last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    int          s;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          legal;
    bit          wr;
    bit          u1;
    bit          u2;
    s      = $signed(w);
    f3     = w[14:12];
    f7     = w[31:25];
    e.pc   = pc;
    e.f3   = f3;
    e.rd   = w[11:7];
    e.rs1  = w[19:15];
    e.rs2  = w[24:20];
    e.alt  = 1'b0;
    e.imm  = 32'd0;
    e.cls  = 4'd0;
    legal  = 1'b1;
    wr     = 1'b0;
    u1     = 1'b0;
    u2     = 1'b0;
    case (w[6:0])
      7'h37: begin e.cls = 4'd1; e.imm = w & 32'hFFFFF000; wr = 1; end
      7'h17: begin e.cls = 4'd2; e.imm = w & 32'hFFFFF000; wr = 1; end
      7'h6F: begin
        e.cls = 4'd3; wr = 1;
        e.imm = (s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      end
      7'h67: begin e.cls = 4'd4; e.imm = s >>> 20; wr = 1; u1 = 1; legal = (f3 == 3'd0); end
      7'h63: begin
        e.cls = 4'd5; u1 = 1; u2 = 1; legal = !(f3 == 3'd2 || f3 == 3'd3);
        e.imm = (s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end
      7'h03: begin
        e.cls = 4'd6; e.imm = s >>> 20; wr = 1; u1 = 1;
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'h23: begin
        e.cls = 4'd7; u1 = 1; u2 = 1; legal = (f3 <= 3'd2);
        e.imm = (s >>> 25) * 32 + int'(w[11:7]);
      end
      7'h13: begin
        e.cls = 4'd8; wr = 1; u1 = 1;
        if (f3 == 3'd1 || f3 == 3'd5) e.imm = int'(w[24:20]);
        else e.imm = s >>> 20;
        if (f3 == 3'd1) legal = (f7 == 7'd0);
        if (f3 == 3'd5) begin
          legal = (f7 == 7'd0) || (f7 == 7'd32);
          e.alt = w[30];
        end
      end
      7'h33: begin
        e.cls = 4'd9; wr = 1; u1 = 1; u2 = 1; e.alt = w[30];
        legal = (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
      end
      default: legal = (w == 32'd0);
    endcase
    e.ill   = !legal;
    e.rd_we = legal && wr && (w[11:7] != 5'd0);
    e.rs1u  = legal && u1;
    e.rs2u  = legal && u2;
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    int          k;
    k = $urandom_range(0, 11);
    w = $urandom;
    if (k == 0) begin
      w = 32'd0;
    end else if (k >= 2) begin
      w[6:0] = OPS[k-2];
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'd0;
        1: w[31:25] = 7'd32;
        default: ;
      endcase
    end
    return w;
  endfunction

  // Called at the falling edge: checks outputs, then advances the model across one rising edge.
  task automatic step();
    bit   acc;
    bit   pp;
    exp_t e;
    check("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
    check("if_ready", 32'(if_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("pc", id_pc, e.pc);
      check("class", 32'(id_class), 32'(e.cls));
      check("funct3", 32'(id_funct3), 32'(e.f3));
      check("alt", 32'(id_alt), 32'(e.alt));
      check("rd", 32'(id_rd), 32'(e.rd));
      check("rs1", 32'(id_rs1), 32'(e.rs1));
      check("rs2", 32'(id_rs2), 32'(e.rs2));
      check("imm", id_imm, e.imm);
      check("rd_we", 32'(id_rd_we), 32'(e.rd_we));
      check("rs1_used", 32'(id_rs1_used), 32'(e.rs1u));
      check("rs2_used", 32'(id_rs2_used), 32'(e.rs2u));
      check("illegal", 32'(id_illegal), 32'(e.ill));
    end
    acc = if_valid && (exp_q.size() < 2);
    pp  = id_ready && (exp_q.size() != 0);
    @(posedge pad_clk);
    if (pad_rst || flush) begin
      exp_q.delete();
      acc = 1'b0;
    end else begin
      if (pp) e = exp_q.pop_front();
      if (acc) exp_q.push_back(ref_decode(if_inst, if_pc));
    end
    last_acc = acc;
    @(negedge pad_clk);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
    id_ready = 1'b1;
    step();
    if_valid = 1'b0;
  endtask

  logic [31:0] bp_words [4];
  int          idx;

  initial begin
    pad_rst  = 1'b1;
    if_valid = 1'b1;
    if_inst  = 32'h123450B7;
    if_pc    = 32'h40;
    flush    = 1'b0;
    id_ready = 1'b0;
    @(posedge pad_clk);
    @(posedge pad_clk);
    @(negedge pad_clk);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd1);
    check("rst_class", 32'(id_class), 32'd0);
    check("rst_imm", id_imm, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_rd_we", 32'(id_rd_we), 32'd0);
    pad_rst  = 1'b0;
    if_valid = 1'b0;

    send(32'h123450B7, 32'h0);
    check("lui_class", 32'(id_class), 32'd1);
    check("lui_rd", 32'(id_rd), 32'd1);
    check("lui_imm", id_imm, 32'h12345000);
    check("lui_rd_we", 32'(id_rd_we), 32'd1);
    check("lui_rs1_used", 32'(id_rs1_used), 32'd0);
    send(32'h180001EF, 32'h8);
    check("jal_class", 32'(id_class), 32'd3);
    check("jal_rd", 32'(id_rd), 32'd3);
    check("jal_imm", id_imm, 32'h00000180);
    check("jal_pc", id_pc, 32'h8);
    send(32'h3E208063, 32'hC);
    check("br_class", 32'(id_class), 32'd5);
    check("br_rs1", 32'(id_rs1), 32'd1);
    check("br_rs2", 32'(id_rs2), 32'd2);
    check("br_f3", 32'(id_funct3), 32'd0);
    check("br_imm", id_imm, 32'h000003E0);
    check("br_rd_we", 32'(id_rd_we), 32'd0);
    send(32'h0020A423, 32'h10);
    check("st_class", 32'(id_class), 32'd7);
    check("st_f3", 32'(id_funct3), 32'd2);
    check("st_imm", id_imm, 32'd8);
    send(32'h402081B3, 32'h14);
    check("sub_class", 32'(id_class), 32'd9);
    check("sub_alt", 32'(id_alt), 32'd1);
    check("sub_rd", 32'(id_rd), 32'd3);
    send(32'h00000000, 32'h18);
    check("nop_class", 32'(id_class), 32'd0);
    check("nop_illegal", 32'(id_illegal), 32'd0);
    check("nop_rd_we", 32'(id_rd_we), 32'd0);
    send(32'hFFFFFFFF, 32'h1C);
    check("ones_illegal", 32'(id_illegal), 32'd1);
    check("ones_rd_we", 32'(id_rd_we), 32'd0);
    step();

    bp_words = '{32'h00100093, 32'h00208133, 32'h0040A183, 32'h40315213};
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      id_ready = (c >= 3);
      if (idx < 4) begin
        if_valid = 1'b1;
        if_inst  = bp_words[idx];
        if_pc    = 32'h100 + 32'(idx) * 4;
      end else begin
        if_valid = 1'b0;
      end
      step();
      if (last_acc) idx++;
      if (c == 2) begin
        check("bp_if_ready_low", 32'(if_ready), 32'd0);
        check("bp_accepts", 32'(idx), 32'd2);
      end
    end
    check("bp_all_accepted", 32'(idx), 32'd4);

    id_ready = 1'b0;
    if_valid = 1'b1;
    if_inst  = 32'h00500293; if_pc = 32'h200; step();
    if_inst  = 32'h00600313; if_pc = 32'h204; step();
    flush    = 1'b1;
    if_inst  = 32'h00700393; if_pc = 32'h208; step();
    flush    = 1'b0;
    if_valid = 1'b0;
    check("flush_id_valid", 32'(id_valid), 32'd0);
    check("flush_if_ready", 32'(if_ready), 32'd1);
    send(32'h00800413, 32'h300);
    check("flush_next_valid", 32'(id_valid), 32'd1);
    check("flush_next_pc", id_pc, 32'h300);

    id_ready = 1'b0;
    if_valid = 1'b1;
    if_inst  = 32'h00900493; if_pc = 32'h400; step();
    if_inst  = 32'h00A00513; if_pc = 32'h404; step();
    pad_rst  = 1'b1;
    step();
    pad_rst  = 1'b0;
    if_valid = 1'b0;
    check("midrst_id_valid", 32'(id_valid), 32'd0);
    check("midrst_if_ready", 32'(if_ready), 32'd1);
    check("midrst_class", 32'(id_class), 32'd0);
    check("midrst_imm", id_imm, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      if_inst  = gen_inst();
      if_pc    = $urandom & 32'hFFFFFFFC;
      id_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 99) < 3);
      pad_rst  = ($urandom_range(0, 199) == 0);
      step();
    end
    flush   = 1'b0;
    pad_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
